mem_arbiter: RTL and testbench
==============================

// Module: mem_arbiter
// PURPOSE
//  Owns the single byte-wide RAM/IO port and shares it between two masters: ICache line refill
//  from instruction fetch, and LSB loads/stores. Converts each granted request into a byte-serial
//  sequence. Assembles 512-bit lines or 32-bit load data, and issues write bytes for stores.
//  Sits between the fetch/LSB units and the top-level memory pins.
// PARAMETERS
//  LINE_BYTES  64        bytes per ICache line (if_data width = 8*LINE_BYTES)
//  IO_SEL      2'b11     value of addr[17:16] that marks the IO region
// PORTS
//  clk            in   1    clock
//  rst            in   1    reset, synchronous, active-high
//  rdy            in   1    global enable; low freezes all state
//  rollback       in   1    ROB flush; aborts fetches and loads
//  if_en          in   1    line refill request, held until if_done
//  if_addr        in   32   line base address (low 6 bits zero)
//  if_done        out  1    one-cycle pulse: if_data valid
//  if_data        out  512  line, byte k at [8k+7:8k]
//  lsb_en         in   1    load/store request, held until lsb_done
//  lsb_wr         in   1    1 = store, 0 = load
//  lsb_len        in   2    0 = byte, 1 = half, 2 = word (3 = word)
//  lsb_addr       in   32   first byte address
//  lsb_wdata      in   32   store data, little-endian
//  lsb_done       out  1    one-cycle pulse: access complete, lsb_rdata valid on loads
//  lsb_rdata      out  32   load data, zero-extended (LSB performs sign extension)
//  mem_din        in   8    RAM read byte, valid the cycle after its address
//  io_buffer_full in   1    IO write buffer full
//  mem_dout       out  8    write byte
//  mem_a          out  32   byte address
//  mem_wr         out  1    1 = write this cycle
// BEHAVIOUR
//  Reset: state IDLE; if_done, lsb_done, mem_wr = 0; mem_a, mem_dout = 0; if_data, lsb_rdata = 0;
//   last_grant = IF, so the LSB wins the first tie.
//  rdy = 0: all registers hold; mem_wr is forced to 0.
//  States: IDLE -> {FETCH, LOAD, STORE} -> DONE -> IDLE.
//   A new request is never accepted in DONE. This guarantees the requester has dropped en.
//  Arbitration (IDLE only):
//   - Only one requester active: grant it.
//   - Both active: grant the one that is not last_grant (alternating priority).
//   - last_grant updates on each grant.
//  Access length N: FETCH = LINE_BYTES; LOAD/STORE = 1/2/4 from lsb_len.
//   Address = base + k, with 32-bit wrap-around.
//  Read timing:
//   - Grant at edge E0. mem_a = base + k in cycle k+1, for k = 0..N-1.
//   - Byte k is captured from mem_din at the end of cycle k+2 into lane k.
//   - Done is high in cycle N+2 with data stable (word load: cycle 6; line: cycle 66).
//  Write timing:
//   - mem_wr = 1, mem_a = base + k, mem_dout = wdata byte k in cycle k+1.
//   - lsb_done is high in cycle N+1.
//  IO stall: a store byte targeting addr[17:16] == IO_SEL is not issued while io_buffer_full = 1.
//   In that cycle mem_wr = 0 and the byte counter holds; the byte is issued on the first cycle
//   io_buffer_full = 0.
//  Rollback:
//   - In FETCH or LOAD: go to IDLE at the next edge; no done pulse; in-flight bytes are discarded.
//   - In STORE: ignored, because stores are committed and the store completes normally.
//   - Rollback asserted in IDLE with requests pending: no grant that cycle.
//  Outside writes, mem_wr = 0. mem_a holds its last value when idle.
//  Reset asserted mid-access: return to the reset state immediately; partial data is dropped.
// STRUCTURE
//  Shared package/header: state encodings, LEN_B/LEN_H/LEN_W codes, IO_SEL, LINE_BYTES.
//  One sub-module: mem_byte_collector.
//   - Interface: lane counter plus shift/insert into a LINE_BYTES-wide register.
//   - Used for both FETCH and LOAD; lsb_rdata = collector[31:0].
//  The arbiter FSM, issue counter and IO-stall logic stay in mem_arbiter.
// TESTING
//  1. Line refill: if_en at 0x1040; RAM[0x1040 + k] = k.
//     -> if_done in cycle 66; if_data byte k == k; mem_wr stays 0.
//  2. Word load: lsb_len = 2 at 0x2000, RAM = 78 56 34 12.
//     -> lsb_rdata = 0x12345678 in cycle 6. Half load -> 0x00005678 in cycle 4.
//  3. Tie: if_en and lsb_en both set from reset.
//     -> LSB granted first, then IF. Repeat the tie -> LSB again (alternation verified over 4 ties).
//  4. Rollback during FETCH at cycle 10.
//     -> IDLE next cycle; if_done never pulses; a new if_en is accepted.
//  5. Rollback during a STORE word to 0x100.
//     -> all 4 bytes are written (mem_wr for 4 cycles); lsb_done pulses.
//  6. Byte store to 0x30000 with io_buffer_full high for 3 cycles.
//     -> mem_wr is delayed exactly 3 cycles; lsb_done follows 1 cycle later. rdy = 0 mid-access
//        freezes the counter and adds its duration to the latency.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// Shared encodings for the memory-port arbiter: FSM states, grant owner, access length codes
// and the address region that maps to IO.
package mem_arbiter_pkg;

  localparam int         LINE_BYTES = 64;
  localparam logic [1:0] IO_SEL     = 2'b11;

  localparam logic [1:0] LEN_B = 2'd0;
  localparam logic [1:0] LEN_H = 2'd1;
  localparam logic [1:0] LEN_W = 2'd2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_LOAD,
    ST_STORE,
    ST_DONE
  } state_e;

  typedef enum logic {
    GR_IF,
    GR_LSB
  } grant_e;

  // Byte count of an LSB access; code 3 behaves as a word.
  function automatic logic [6:0] lsb_len_bytes(input logic [1:0] len);
    case (len)
      LEN_B:   return 7'd1;
      LEN_H:   return 7'd2;
      default: return 7'd4;
    endcase
  endfunction

  function automatic logic is_io(input logic [1:0] region, input logic [1:0] sel);
    return region == sel;
  endfunction

endpackage

// File: rtl/mem_byte_collector.sv
// Gathers read bytes into a line-wide register, one lane per captured byte.
// Cleared at the start of every read so short loads come out zero-extended.
module mem_byte_collector #(
  parameter int LINE_BYTES = mem_arbiter_pkg::LINE_BYTES
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic                    clear,
  input  logic                    cap,
  input  logic [7:0]              din,
  output logic [$clog2(LINE_BYTES)-1:0] lane,
  output logic [8*LINE_BYTES-1:0] data
);
  import mem_arbiter_pkg::*;

  localparam int LW = $clog2(LINE_BYTES);

  always_ff @(posedge clk) begin
    if (rst) begin
      lane <= '0;
      data <= '0;
    end else if (en) begin
      if (clear) begin
        lane <= '0;
        data <= '0;
      end else if (cap) begin
        data[{lane, 3'b000} +: 8] <= din;
        lane                      <= lane + LW'(1);
      end
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares the byte-wide memory port between ICache refill and LSB loads/stores, turning each
// granted request into a byte-serial access with alternating priority on ties.
module mem_arbiter #(
  parameter int         LINE_BYTES = mem_arbiter_pkg::LINE_BYTES,
  parameter logic [1:0] IO_SEL     = mem_arbiter_pkg::IO_SEL
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    rdy,
  input  logic                    rollback,
  input  logic                    if_en,
  input  logic [31:0]             if_addr,
  output logic                    if_done,
  output logic [8*LINE_BYTES-1:0] if_data,
  input  logic                    lsb_en,
  input  logic                    lsb_wr,
  input  logic [1:0]              lsb_len,
  input  logic [31:0]             lsb_addr,
  input  logic [31:0]             lsb_wdata,
  output logic                    lsb_done,
  output logic [31:0]             lsb_rdata,
  input  logic [7:0]              mem_din,
  input  logic                    io_buffer_full,
  output logic [7:0]              mem_dout,
  output logic [31:0]             mem_a,
  output logic                    mem_wr
);
  import mem_arbiter_pkg::*;

  localparam int LW = $clog2(LINE_BYTES);
  localparam int CW = LW + 1;

  // Handshake: a requester raises en with stable fields and holds it until its one-cycle done
  // pulse; the done cycle is spent in ST_DONE so a dropped en is never mistaken for a new one.
  state_e            state;
  grant_e            last_grant;
  logic [31:0]       base;
  logic [31:0]       wdata;
  logic [CW-1:0]     n_bytes;
  logic [CW-1:0]     issue_cnt;
  logic              rd_prime;
  logic              mem_wr_q;
  logic [LW-1:0]     lane;
  logic [8*LINE_BYTES-1:0] line;

  logic        rd_state, pick_lsb, grant, clear, cap, cap_last, store_stall;
  logic [31:0] next_addr;
  logic [7:0]  next_byte;

  assign rd_state    = (state == ST_FETCH) || (state == ST_LOAD);
  assign pick_lsb    = lsb_en && (!if_en || last_grant == GR_IF);
  assign grant       = (state == ST_IDLE) && !rollback && (if_en || lsb_en);
  assign clear       = grant && !(pick_lsb && lsb_wr);
  // The first read cycle sees mem_din for an address issued before the grant, so skip it.
  assign cap         = rd_state && !rd_prime;
  assign cap_last    = cap && ({1'b0, lane} == n_bytes - CW'(1));
  assign next_addr   = base + 32'(issue_cnt);
  assign next_byte   = wdata[{issue_cnt[1:0], 3'b000} +: 8];
  assign store_stall = io_buffer_full && is_io(next_addr[17:16], IO_SEL);

  assign mem_wr    = mem_wr_q && rdy;
  assign if_data   = line;
  assign lsb_rdata = line[31:0];

  mem_byte_collector #(.LINE_BYTES(LINE_BYTES)) u_collector (
    .clk   (clk),
    .rst   (rst),
    .en    (rdy),
    .clear (clear),
    .cap   (cap),
    .din   (mem_din),
    .lane  (lane),
    .data  (line)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      last_grant <= GR_IF;
      base       <= '0;
      wdata      <= '0;
      n_bytes    <= '0;
      issue_cnt  <= '0;
      rd_prime   <= 1'b0;
      mem_wr_q   <= 1'b0;
      mem_a      <= '0;
      mem_dout   <= '0;
      if_done    <= 1'b0;
      lsb_done   <= 1'b0;
    end else if (rdy) begin
      case (state)
        ST_IDLE: begin
          if_done  <= 1'b0;
          lsb_done <= 1'b0;
          mem_wr_q <= 1'b0;
          if (grant) begin
            last_grant <= pick_lsb ? GR_LSB : GR_IF;
            rd_prime   <= 1'b1;
            if (pick_lsb) begin
              base    <= lsb_addr;
              wdata   <= lsb_wdata;
              n_bytes <= CW'(lsb_len_bytes(lsb_len));
              if (lsb_wr) begin
                state <= ST_STORE;
                if (io_buffer_full && is_io(lsb_addr[17:16], IO_SEL)) begin
                  issue_cnt <= '0;
                end else begin
                  mem_wr_q  <= 1'b1;
                  mem_a     <= lsb_addr;
                  mem_dout  <= lsb_wdata[7:0];
                  issue_cnt <= CW'(1);
                end
              end else begin
                state     <= ST_LOAD;
                mem_a     <= lsb_addr;
                issue_cnt <= CW'(1);
              end
            end else begin
              state     <= ST_FETCH;
              base      <= if_addr;
              n_bytes   <= CW'(LINE_BYTES);
              mem_a     <= if_addr;
              issue_cnt <= CW'(1);
            end
          end
        end

        ST_FETCH, ST_LOAD: begin
          rd_prime <= 1'b0;
          if (rollback) begin
            state <= ST_IDLE;
          end else begin
            if (issue_cnt < n_bytes) begin
              mem_a     <= next_addr;
              issue_cnt <= issue_cnt + CW'(1);
            end
            if (cap_last) begin
              state <= ST_DONE;
              if (state == ST_FETCH) if_done  <= 1'b1;
              else                   lsb_done <= 1'b1;
            end
          end
        end

        // Stores are already committed, so rollback is deliberately ignored here.
        ST_STORE: begin
          if (issue_cnt == n_bytes) begin
            mem_wr_q <= 1'b0;
            lsb_done <= 1'b1;
            state    <= ST_DONE;
          end else if (store_stall) begin
            mem_wr_q <= 1'b0;
          end else begin
            mem_wr_q  <= 1'b1;
            mem_a     <= next_addr;
            mem_dout  <= next_byte;
            issue_cnt <= issue_cnt + CW'(1);
          end
        end

        ST_DONE: begin
          if_done  <= 1'b0;
          lsb_done <= 1'b0;
          state    <= ST_IDLE;
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: byte-addressed RAM model, per-scenario tasks with inline
// checks against hand-computed cycle counts and data, and a write queue for stores.
module tb_mem_arbiter;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         rdy = 1'b1;
  logic         rollback = 1'b0;
  logic         if_en = 1'b0;
  logic [31:0]  if_addr = '0;
  logic         if_done;
  logic [511:0] if_data;
  logic         lsb_en = 1'b0;
  logic         lsb_wr = 1'b0;
  logic [1:0]   lsb_len = 2'd0;
  logic [31:0]  lsb_addr = '0;
  logic [31:0]  lsb_wdata = '0;
  logic         lsb_done;
  logic [31:0]  lsb_rdata;
  logic [7:0]   mem_din;
  logic         io_buffer_full = 1'b0;
  logic [7:0]   mem_dout;
  logic [31:0]  mem_a;
  logic         mem_wr;

  int n_vec = 0;
  int n_err = 0;

  logic [7:0]   ram [0:262143];
  logic [39:0]  wr_q[$];
  logic [39:0]  exp_q[$];

  int           done_c, first_wr_c, wr_n;
  logic [511:0] line_q;
  logic [31:0]  rdata_q;
  logic [31:0]  a_tr [0:127];
  logic [511:0] exp_line;

  always #5 clk = ~clk;

  mem_arbiter dut (
    .clk(clk), .rst(rst), .rdy(rdy), .rollback(rollback),
    .if_en(if_en), .if_addr(if_addr), .if_done(if_done), .if_data(if_data),
    .lsb_en(lsb_en), .lsb_wr(lsb_wr), .lsb_len(lsb_len), .lsb_addr(lsb_addr),
    .lsb_wdata(lsb_wdata), .lsb_done(lsb_done), .lsb_rdata(lsb_rdata),
    .mem_din(mem_din), .io_buffer_full(io_buffer_full), .mem_dout(mem_dout),
    .mem_a(mem_a), .mem_wr(mem_wr)
  );

  // RAM: read data one cycle after its address; writes logged for the scoreboard.
  always @(posedge clk) begin
    mem_din <= ram[mem_a[17:0]];
    if (mem_wr === 1'b1) begin
      ram[mem_a[17:0]] <= mem_dout;
      if (!rst) wr_q.push_back({mem_a, mem_dout});
    end
  end

  initial begin
    for (int i = 0; i < 262144; i++) ram[i] <= 8'(i & 63);
    ram[18'h02000] <= 8'h78; ram[18'h02001] <= 8'h56;
    ram[18'h02002] <= 8'h34; ram[18'h02003] <= 8'h12;
    ram[18'h3FFFE] <= 8'hAA; ram[18'h3FFFF] <= 8'hBB;
    ram[18'h00000] <= 8'hCC; ram[18'h00001] <= 8'hDD;
    for (int k = 0; k < 64; k++) exp_line[8*k +: 8] = 8'(k);
  end

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic apply_reset;
    rst = 1'b1; if_en = 1'b0; lsb_en = 1'b0; rollback = 1'b0; rdy = 1'b1; io_buffer_full = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  // Drives one request (cycle 0 = setup cycle, grant at its closing edge) and records results.
  task automatic drive_req(input bit is_if, input bit wr, input logic [1:0] len,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           input int io_n = 0, input int rb_at = -5, input bit drop_rb = 1'b0,
                           input int rdy_at = -100, input int rdy_n = 0);
    done_c = -1; first_wr_c = -1; wr_n = 0;
    @(negedge clk);
    if (is_if) begin
      if_en = 1'b1; if_addr = addr;
    end else begin
      lsb_en = 1'b1; lsb_wr = wr; lsb_len = len; lsb_addr = addr; lsb_wdata = wdata;
    end
    if (io_n > 0) io_buffer_full = 1'b1;
    if (rb_at == 0) rollback = 1'b1;
    for (int c = 1; c <= 100 && done_c < 0; c++) begin
      @(negedge clk);
      if (c < 128) a_tr[c] = mem_a;
      if (mem_wr) begin
        wr_n++;
        if (first_wr_c < 0) first_wr_c = c;
      end
      if (if_done || lsb_done) begin
        done_c = c; line_q = if_data; rdata_q = lsb_rdata; if_en = 1'b0; lsb_en = 1'b0;
      end
      if (c == io_n) io_buffer_full = 1'b0;
      if (c == rb_at) begin
        rollback = 1'b1;
        if (drop_rb) begin if_en = 1'b0; lsb_en = 1'b0; end
      end
      if (c == rb_at + 1) rollback = 1'b0;
      if (c == rdy_at) rdy = 1'b0;
      if (c == rdy_at + rdy_n) rdy = 1'b1;
    end
    if_en = 1'b0; lsb_en = 1'b0; rollback = 1'b0; rdy = 1'b1; io_buffer_full = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic check_writes(input string name);
    logic [39:0] got, want;
    while (exp_q.size() > 0) begin
      want = exp_q.pop_front();
      got  = (wr_q.size() > 0) ? wr_q.pop_front() : 'x;
      n_vec++;
      if (got !== want) begin n_err++; $display("FAIL %s_write got %h want %h", name, got, want); end
    end
    n_vec++;
    if (wr_q.size() != 0) begin n_err++; $display("FAIL %s_extra_writes got %0d want 0", name, wr_q.size()); end
    wr_q.delete();
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    n_vec++; if (if_done !== 1'b0) begin n_err++; $display("FAIL reset_if_done got %b want 0", if_done); end
    n_vec++; if (lsb_done !== 1'b0) begin n_err++; $display("FAIL reset_lsb_done got %b want 0", lsb_done); end
    n_vec++; if (mem_wr !== 1'b0) begin n_err++; $display("FAIL reset_mem_wr got %b want 0", mem_wr); end
    n_vec++; if (mem_a !== 32'h0) begin n_err++; $display("FAIL reset_mem_a got %h want 0", mem_a); end
    n_vec++; if (mem_dout !== 8'h0) begin n_err++; $display("FAIL reset_mem_dout got %h want 0", mem_dout); end
    n_vec++; if (if_data !== 512'h0) begin n_err++; $display("FAIL reset_if_data nonzero"); end
    n_vec++; if (lsb_rdata !== 32'h0) begin n_err++; $display("FAIL reset_lsb_rdata got %h want 0", lsb_rdata); end
    rst = 1'b0;
    repeat (2) @(negedge clk);
    n_vec++; if (mem_wr !== 1'b0) begin n_err++; $display("FAIL idle_mem_wr got %b want 0", mem_wr); end
  endtask

  task automatic test_line_refill;
    drive_req(1'b1, 1'b0, 2'd0, 32'h1040, 32'h0);
    n_vec++; if (done_c != 66) begin n_err++; $display("FAIL line_done_cycle got %0d want 66", done_c); end
    n_vec++; if (line_q !== exp_line) begin n_err++; $display("FAIL line_data got %h want %h", line_q, exp_line); end
    n_vec++; if (wr_n != 0) begin n_err++; $display("FAIL line_mem_wr got %0d want 0", wr_n); end
    n_vec++; if (a_tr[1] !== 32'h1040) begin n_err++; $display("FAIL line_addr_first got %h want 1040", a_tr[1]); end
    n_vec++; if (a_tr[64] !== 32'h107F) begin n_err++; $display("FAIL line_addr_last got %h want 107f", a_tr[64]); end
  endtask

  task automatic test_loads;
    drive_req(1'b0, 1'b0, 2'd2, 32'h2000, 32'h0);
    n_vec++; if (done_c != 6) begin n_err++; $display("FAIL word_done_cycle got %0d want 6", done_c); end
    n_vec++; if (rdata_q !== 32'h12345678) begin n_err++; $display("FAIL word_data got %h want 12345678", rdata_q); end
    n_vec++; if (a_tr[4] !== 32'h2003) begin n_err++; $display("FAIL word_addr_last got %h want 2003", a_tr[4]); end
    drive_req(1'b0, 1'b0, 2'd1, 32'h2000, 32'h0);
    n_vec++; if (done_c != 4) begin n_err++; $display("FAIL half_done_cycle got %0d want 4", done_c); end
    n_vec++; if (rdata_q !== 32'h00005678) begin n_err++; $display("FAIL half_data got %h want 00005678", rdata_q); end
    drive_req(1'b0, 1'b0, 2'd3, 32'hFFFFFFFE, 32'h0);
    n_vec++; if (done_c != 6) begin n_err++; $display("FAIL wrap_done_cycle got %0d want 6", done_c); end
    n_vec++; if (rdata_q !== 32'hDDCCBBAA) begin n_err++; $display("FAIL wrap_data got %h want ddccbbaa", rdata_q); end
    // Rollback in IDLE with a pending byte load delays the grant by one cycle.
    drive_req(1'b0, 1'b0, 2'd0, 32'h2000, 32'h0, 0, 0);
    n_vec++; if (done_c != 4) begin n_err++; $display("FAIL idle_rb_done_cycle got %0d want 4", done_c); end
    n_vec++; if (rdata_q !== 32'h00000078) begin n_err++; $display("FAIL idle_rb_data got %h want 00000078", rdata_q); end
  endtask

  task automatic test_tie;
    logic [7:0] first;
    bit got_i, got_l;
    apply_reset;
    for (int t = 0; t < 5; t++) begin
      if (t == 4) drive_req(1'b0, 1'b0, 2'd0, 32'h2000, 32'h0);
      @(negedge clk);
      if_en = 1'b1; if_addr = 32'h1040;
      lsb_en = 1'b1; lsb_wr = 1'b0; lsb_len = 2'd0; lsb_addr = 32'h2000;
      first = "N"; got_i = 1'b0; got_l = 1'b0;
      for (int c = 0; c < 300 && !(got_i && got_l); c++) begin
        @(negedge clk);
        if (lsb_done) begin if (first == "N") first = "L"; got_l = 1'b1; lsb_en = 1'b0; end
        if (if_done) begin if (first == "N") first = "I"; got_i = 1'b1; if_en = 1'b0; end
      end
      if_en = 1'b0; lsb_en = 1'b0;
      n_vec++;
      if (first !== ((t == 4) ? "I" : "L")) begin
        n_err++; $display("FAIL tie%0d_first got %s want %s", t, first, (t == 4) ? "I" : "L");
      end
      n_vec++; if (!(got_i && got_l)) begin n_err++; $display("FAIL tie%0d_both got %b%b want 11", t, got_i, got_l); end
      repeat (2) @(negedge clk);
    end
  endtask

  task automatic test_rollback_fetch;
    drive_req(1'b1, 1'b0, 2'd0, 32'h1040, 32'h0, 0, 10, 1'b1);
    n_vec++; if (done_c != -1) begin n_err++; $display("FAIL rb_fetch_done got %0d want -1", done_c); end
    n_vec++; if (a_tr[12] !== 32'h1049) begin n_err++; $display("FAIL rb_fetch_addr_hold got %h want 1049", a_tr[12]); end
    drive_req(1'b1, 1'b0, 2'd0, 32'h1080, 32'h0);
    n_vec++; if (done_c != 66) begin n_err++; $display("FAIL rb_refetch_done got %0d want 66", done_c); end
    n_vec++; if (line_q !== exp_line) begin n_err++; $display("FAIL rb_refetch_data got %h want %h", line_q, exp_line); end
  endtask

  task automatic test_stores;
    wr_q.delete();
    exp_q.push_back({32'h100, 8'hD4}); exp_q.push_back({32'h101, 8'hC3});
    exp_q.push_back({32'h102, 8'hB2}); exp_q.push_back({32'h103, 8'hA1});
    drive_req(1'b0, 1'b1, 2'd2, 32'h100, 32'hA1B2C3D4, 0, 2, 1'b0);
    n_vec++; if (wr_n != 4) begin n_err++; $display("FAIL st_rb_wr_cycles got %0d want 4", wr_n); end
    n_vec++; if (done_c != 5) begin n_err++; $display("FAIL st_rb_done got %0d want 5", done_c); end
    check_writes("st_rb");

    exp_q.push_back({32'h30000, 8'h5A});
    drive_req(1'b0, 1'b1, 2'd0, 32'h30000, 32'h0000005A, 3);
    n_vec++; if (first_wr_c != 4) begin n_err++; $display("FAIL io_first_wr got %0d want 4", first_wr_c); end
    n_vec++; if (done_c != 5) begin n_err++; $display("FAIL io_done got %0d want 5", done_c); end
    n_vec++; if (wr_n != 1) begin n_err++; $display("FAIL io_wr_cycles got %0d want 1", wr_n); end
    check_writes("io");

    exp_q.push_back({32'h200, 8'h44}); exp_q.push_back({32'h201, 8'h33});
    exp_q.push_back({32'h202, 8'h22}); exp_q.push_back({32'h203, 8'h11});
    drive_req(1'b0, 1'b1, 2'd2, 32'h200, 32'h11223344, 0, -5, 1'b0, 2, 2);
    n_vec++; if (wr_n != 4) begin n_err++; $display("FAIL rdy_wr_cycles got %0d want 4", wr_n); end
    n_vec++; if (done_c != 7) begin n_err++; $display("FAIL rdy_done got %0d want 7", done_c); end
    check_writes("rdy");
  endtask

  initial begin
    test_reset;
    test_line_refill;
    test_loads;
    test_tie;
    test_rollback_fetch;
    test_stores;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
